mul_div_unit: RTL

//  Iterative RV32M multiply/divide execute stage. Consumes the two register-file read operands
//  (RD1/RD2) and produces the writeback word, destination index and write enable for the

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core execute stage and the iterative RV32M mul/div unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [4:0]      RdIn;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic [4:0]      RdOut;
  logic            WE;

  modport master (
    output Start, Funct3, SrcA, SrcB, RdIn,
    input  Busy, Done, Result, RdOut, WE
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, RdIn,
    output Busy, Done, Result, RdOut, WE
  );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative RV32M multiply/divide unit: one product/quotient bit per clock,
// Start/Busy/Done handshake, writeback word/index/enable for the register file.
module mul_div_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave io
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      funct_q, funct_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic            neg_q, neg_d, div0_q, div0_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            a_signed, b_signed, sign_a, sign_b;
  logic            req_div0, req_ovf, req_special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [XLEN-1:0]   hi_step, lo_step, quo, rem, final_res;
  logic [2*XLEN-1:0] prod;

  // Request decode: operand magnitudes, result sign and the divide corner cases
  always_comb begin
    a_signed    = io.Funct3[2] ? ~io.Funct3[0] : (io.Funct3[1] ^ io.Funct3[0]);
    b_signed    = io.Funct3[2] ? ~io.Funct3[0] : (io.Funct3[1:0] == 2'b01);
    sign_a      = a_signed & io.SrcA[XLEN-1];
    sign_b      = b_signed & io.SrcB[XLEN-1];
    mag_a       = sign_a ? -io.SrcA : io.SrcA;
    mag_b       = sign_b ? -io.SrcB : io.SrcB;
    req_div0    = io.Funct3[2] & (io.SrcB == '0);
    req_ovf     = io.Funct3[2] & ~io.Funct3[0] & (io.SrcA == MIN_NEG) & (io.SrcB == '1);
    req_special = FAST_SPECIAL & (req_div0 | req_ovf);
    if (req_div0) special_res = io.Funct3[1] ? io.SrcA : '1;
    else          special_res = io.Funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration step; hi holds the running sum/remainder, lo the multiplier/quotient bits
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (funct_q[2]) begin
      if (!div_diff[XLEN]) begin
        hi_step = div_diff[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = div_sh[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod = neg_q ? -{hi_step, lo_step} : {hi_step, lo_step};
    // Iterated divide-by-zero would yield all-ones magnitude, which a sign fix would corrupt
    quo  = div0_q ? '1 : (neg_q ? -lo_step : lo_step);
    rem  = neg_q ? -hi_step : hi_step;
    case (funct_q)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_ff @(posedge clk) begin
    funct_q <= funct_d;
    rd_q    <= rd_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    b_q     <= b_d;
    neg_q   <= neg_d;
    div0_q  <= div0_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (io.Start) state_d = req_special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == LAST_CNT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    rd_d     = rd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (io.Start) begin
          funct_d = io.Funct3;
          rd_d    = io.RdIn;
          cnt_d   = '0;
          neg_d   = (io.Funct3[2] & io.Funct3[1]) ? sign_a : (sign_a ^ sign_b);
          div0_d  = req_div0;
          hi_d    = '0;
          lo_d    = io.Funct3[2] ? mag_a : mag_b;
          b_d     = io.Funct3[2] ? mag_b : mag_a;
          if (req_special) begin
            result_d = special_res;
            rd_out_d = io.RdIn;
          end
        end
      end
      S_CALC: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    io.Busy   = (state_q != S_IDLE);
    io.Done   = (state_q == S_DONE);
    io.WE     = (state_q == S_DONE) & (rd_out_q != 5'd0);
    io.Result = result_q;
    io.RdOut  = rd_out_q;
  end

endmodule
